// File: rtl/hvsp_responder_if.sv
// HVSP responder link bundle: pin-level SCI/SDI/SII/SDO plus the local
// receive and transmit-hold handshake seen by the target-side logic.
interface hvsp_responder_if;
  logic       hv_en;
  logic       sci;
  logic       sdi;
  logic       sii;
  logic       sdo;
  logic       sdo_oe;
  logic       rx_valid;
  logic [7:0] rx_sdi;
  logic [7:0] rx_sii;
  logic       rx_err;
  logic       frame_abort;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       busy;

  modport master (
    output hv_en, sci, sdi, sii, tx_data, tx_load,
    input  sdo, sdo_oe, rx_valid, rx_sdi, rx_sii, rx_err, frame_abort, tx_ready, busy
  );

  modport slave (
    input  hv_en, sci, sdi, sii, tx_data, tx_load,
    output sdo, sdo_oe, rx_valid, rx_sdi, rx_sii, rx_err, frame_abort, tx_ready, busy
  );
endinterface

// File: rtl/hvsp_responder.sv
// Target-side HVSP responder: oversamples SCI/SDI/SII, deframes 11-bit
// instruction frames into byte pairs and shifts a held response byte out on SDO.
module hvsp_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 240
) (
  input logic             osc,
  input logic             rst_n,
  hvsp_responder_if.slave bus
);

  localparam int unsigned TmoW      = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  FrameBits = 4'd11;

  logic [SYNC_STAGES-1:0] sci_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic [SYNC_STAGES-1:0] sii_sync_q;
  logic                   sci_hist_q;
  logic                   sci_s;
  logic                   sdi_s;
  logic                   sii_s;
  logic                   rise;
  logic                   fall;

  logic [3:0]      cnt_q;
  logic [10:0]     sh_sdi_q;
  logic [10:0]     sh_sii_q;
  logic [7:0]      tx_sh_q;
  logic [7:0]      hold_q;
  logic            hold_full_q;
  logic [TmoW-1:0] tmo_q;
  logic            sdo_q;
  logic            sdo_oe_q;
  logic            rx_valid_q;
  logic [7:0]      rx_sdi_q;
  logic [7:0]      rx_sii_q;
  logic            rx_err_q;
  logic            abort_q;

  logic            busy;
  logic            frame_done;
  logic            timeout_hit;
  logic            consume;
  logic            accept;
  logic [7:0]      tx_src;

  // Input synchronizers, all three lines with equal depth so data stays aligned
  // with the SCI edge that qualifies it.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sci_sync_q <= '0;
      sdi_sync_q <= '0;
      sii_sync_q <= '0;
      sci_hist_q <= 1'b0;
    end else begin
      sci_sync_q <= {sci_sync_q[SYNC_STAGES-2:0], bus.sci};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
      sii_sync_q <= {sii_sync_q[SYNC_STAGES-2:0], bus.sii};
      sci_hist_q <= sci_s;
    end
  end

  assign sci_s = sci_sync_q[SYNC_STAGES-1];
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
  assign sii_s = sii_sync_q[SYNC_STAGES-1];

  assign rise = sci_s & ~sci_hist_q & bus.hv_en;
  assign fall = ~sci_s & sci_hist_q & bus.hv_en;

  assign busy        = (cnt_q != 4'd0);
  assign frame_done  = (cnt_q == FrameBits);
  assign timeout_hit = busy && !rise && !fall && (tmo_q == TmoW'(TIMEOUT - 1));

  // The consume at fall #1 sees the pre-edge hold state; a same-cycle load
  // therefore lands in the hold for the following frame.
  assign consume = fall && (cnt_q == 4'd1);
  assign accept  = bus.tx_load && !hold_full_q;
  assign tx_src  = hold_full_q ? hold_q : 8'h00;

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      sh_sdi_q    <= '0;
      sh_sii_q    <= '0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tmo_q       <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_sdi_q    <= '0;
      rx_sii_q    <= '0;
      rx_err_q    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      sdo_oe_q   <= bus.hv_en;

      if (!bus.hv_en) begin
        cnt_q       <= 4'd0;
        sdo_q       <= 1'b0;
        tmo_q       <= '0;
        hold_full_q <= 1'b0;
        // cnt is forced to zero here, so this fires only on the first low cycle
        abort_q     <= busy;
      end else begin
        if (consume) begin
          hold_full_q <= 1'b0;
        end
        if (accept) begin
          hold_q      <= bus.tx_data;
          hold_full_q <= 1'b1;
        end

        if (rise || fall || !busy || timeout_hit) begin
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end

        if (frame_done) begin
          cnt_q      <= 4'd0;
          rx_valid_q <= 1'b1;
          rx_sdi_q   <= sh_sdi_q[9:2];
          rx_sii_q   <= sh_sii_q[9:2];
          rx_err_q   <= sh_sdi_q[10] | sh_sdi_q[1] | sh_sdi_q[0] |
                        sh_sii_q[10] | sh_sii_q[1] | sh_sii_q[0];
          sdo_q      <= 1'b0;
        end else if (timeout_hit) begin
          cnt_q   <= 4'd0;
          sdo_q   <= 1'b0;
          abort_q <= 1'b1;
        end else begin
          if (rise) begin
            sh_sdi_q <= {sh_sdi_q[9:0], sdi_s};
            sh_sii_q <= {sh_sii_q[9:0], sii_s};
            cnt_q    <= cnt_q + 4'd1;
          end

          // SDO only moves on falls; zeros shifted in cover the stop bits.
          if (!busy) begin
            sdo_q <= 1'b0;
          end else if (fall) begin
            if (cnt_q == 4'd1) begin
              sdo_q   <= tx_src[7];
              tx_sh_q <= {tx_src[6:0], 1'b0};
            end else begin
              sdo_q   <= tx_sh_q[7];
              tx_sh_q <= {tx_sh_q[6:0], 1'b0};
            end
          end
        end
      end
    end
  end

  assign bus.sdo         = sdo_q;
  assign bus.sdo_oe      = sdo_oe_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_sdi      = rx_sdi_q;
  assign bus.rx_sii      = rx_sii_q;
  assign bus.rx_err      = rx_err_q;
  assign bus.frame_abort = abort_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_hvsp_responder.sv
// Directed and randomized frames against a frame-level model of the HVSP
// target: decoded bytes, framing errors, SDO response byte and hold handshake.
module tb_hvsp_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 240;

  logic osc;
  logic rst_n;

  hvsp_responder_if bus ();

  hvsp_responder #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .osc  (osc),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial osc = 1'b0;
  always #21 osc = ~osc;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int abort_cnt = 0;

  // Model of the single-entry response hold
  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;

  always @(negedge osc) begin
    if (bus.rx_valid)    rx_cnt++;
    if (bus.frame_abort) abort_cnt++;
  end

  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sdo"},         32'(bus.sdo), 0);
    check({tag, " sdo_oe"},      32'(bus.sdo_oe), 0);
    check({tag, " rx_valid"},    32'(bus.rx_valid), 0);
    check({tag, " rx_sdi"},      32'(bus.rx_sdi), 0);
    check({tag, " rx_sii"},      32'(bus.rx_sii), 0);
    check({tag, " rx_err"},      32'(bus.rx_err), 0);
    check({tag, " frame_abort"}, 32'(bus.frame_abort), 0);
    check({tag, " tx_ready"},    32'(bus.tx_ready), 1);
    check({tag, " busy"},        32'(bus.busy), 0);
  endtask

  task automatic load_tx(input logic [7:0] v, input string tag);
    check({tag, " tx_ready before load"}, 32'(bus.tx_ready), 32'(!m_full));
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    tick();
    bus.tx_load = 1'b0;
    if (!m_full) begin
      m_hold = v;
      m_full = 1'b1;
    end
    tick();
    check({tag, " tx_ready after load"}, 32'(bus.tx_ready), 0);
  endtask

  // Clocks nrises bits of an 11-bit frame with 6-high/7-low SCI timing and
  // collects SDO as the initiator would see it just before each fall.
  task automatic send_frame(input logic [10:0] fsdi, input logic [10:0] fsii, input int nrises,
                            input bit load_f1, input logic [7:0] load_val, input string tag);
    logic [7:0]  exp_byte;
    logic        was_full;
    logic [10:0] seen;
    int          rx0;
    exp_byte = m_full ? m_hold : 8'h00;
    was_full = m_full;
    m_full   = 1'b0;
    if (load_f1 && !was_full) begin
      m_hold = load_val;
      m_full = 1'b1;
    end
    seen = '0;
    rx0  = rx_cnt;
    for (int k = 1; k <= nrises; k++) begin
      bus.sdi = fsdi[11-k];
      bus.sii = fsii[11-k];
      bus.sci = 1'b1;
      repeat (6) tick();
      seen[11-k] = bus.sdo;
      bus.sci = 1'b0;
      if (k == 1 && load_f1) begin
        repeat (SYNC) tick();
        bus.tx_data = load_val;
        bus.tx_load = 1'b1;
        tick();
        bus.tx_load = 1'b0;
        repeat (7 - SYNC - 1) tick();
      end else begin
        repeat (7) tick();
      end
      if (k == 1) check({tag, " tx_ready after fall1"}, 32'(bus.tx_ready), 32'(!m_full));
    end
    if (nrises == 11) begin
      check({tag, " sdo bits"}, 32'(seen), 32'({1'b0, exp_byte, 2'b00}));
      check({tag, " rx_valid count"}, 32'(rx_cnt - rx0), 1);
      check({tag, " rx_sdi"}, 32'(bus.rx_sdi), 32'(fsdi[9:2]));
      check({tag, " rx_sii"}, 32'(bus.rx_sii), 32'(fsii[9:2]));
      check({tag, " rx_err"}, 32'(bus.rx_err),
            32'(fsdi[10] | fsdi[1] | fsdi[0] | fsii[10] | fsii[1] | fsii[0]));
      check({tag, " busy after"}, 32'(bus.busy), 0);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b0, b, 2'b00};
  endfunction

  initial begin
    int          rx0;
    int          ab0;
    int          waited;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  bt;
    logic [2:0]  fb;
    logic [10:0] fs;
    logic [10:0] fi;

    rst_n       = 1'b0;
    bus.hv_en   = 1'b0;
    bus.sci     = 1'b0;
    bus.sdi     = 1'b0;
    bus.sii     = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");

    rst_n     = 1'b1;
    bus.hv_en = 1'b1;
    repeat (4) tick();
    check("sdo_oe with hv_en", 32'(bus.sdo_oe), 1);

    send_frame(frame(8'h40), frame(8'h4C), 11, 1'b0, 8'h00, "f40_4c");

    load_tx(8'hA5, "ldA5");
    send_frame(frame(8'h13), frame(8'h5E), 11, 1'b0, 8'h00, "txA5");

    send_frame(frame(8'h21), frame(8'h68), 11, 1'b1, 8'h3C, "ld_at_fall1");
    send_frame(frame(8'h00), frame(8'h6C), 11, 1'b0, 8'h00, "tx3C");

    send_frame(11'h7FF, frame(8'h4C), 11, 1'b0, 8'h00, "start_err");

    // Stall mid-frame: expect a timeout abort about TMO cycles after the last fall.
    rx0 = rx_cnt;
    ab0 = abort_cnt;
    send_frame(frame(8'hAA), frame(8'h55), 5, 1'b0, 8'h00, "stall");
    check("no early abort", 32'(abort_cnt - ab0), 0);
    waited = 7;
    while (abort_cnt == ab0 && waited < 400) begin
      tick();
      waited++;
    end
    check("timeout abort window",
          32'(waited >= TMO && waited <= TMO + 8), 1);
    repeat (3) tick();
    check("timeout abort single", 32'(abort_cnt - ab0), 1);
    check("timeout busy", 32'(bus.busy), 0);
    check("timeout no rx_valid", 32'(rx_cnt - rx0), 0);
    send_frame(frame(8'h12), frame(8'h34), 11, 1'b0, 8'h00, "after_tmo");

    for (int i = 0; i < 8; i++) begin
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      bt = 8'($urandom);
      fs = frame(b1);
      fi = frame(b2);
      if ($urandom_range(0, 3) == 0) begin
        fb = 3'($urandom_range(1, 7));
        fs = {fb[2], b1, fb[1:0]};
      end
      if ($urandom_range(0, 3) == 0) begin
        fb = 3'($urandom_range(1, 7));
        fi = {fb[2], b2, fb[1:0]};
      end
      if ($urandom_range(0, 1) == 1) load_tx(bt, "rnd_ld");
      send_frame(fs, fi, 11, ($urandom_range(0, 3) == 0), 8'($urandom), "rnd");
    end

    // Drop programming mode mid-frame.
    ab0 = abort_cnt;
    rx0 = rx_cnt;
    send_frame(frame(8'hC3), frame(8'h3C), 3, 1'b0, 8'h00, "hv_drop");
    bus.hv_en = 1'b0;
    tick();
    check("hv_drop sdo_oe", 32'(bus.sdo_oe), 0);
    repeat (4) tick();
    m_full = 1'b0;
    check("hv_drop abort once", 32'(abort_cnt - ab0), 1);
    check("hv_drop busy", 32'(bus.busy), 0);
    check("hv_drop tx_ready", 32'(bus.tx_ready), 1);
    check("hv_drop sdo", 32'(bus.sdo), 0);
    check("hv_drop no rx_valid", 32'(rx_cnt - rx0), 0);
    bus.hv_en = 1'b1;
    repeat (4) tick();

    // Asynchronous reset mid-frame.
    load_tx(8'h5A, "rst_ld");
    ab0 = abort_cnt;
    rx0 = rx_cnt;
    send_frame(frame(8'hFF), frame(8'h81), 4, 1'b0, 8'h00, "rst_mid");
    bus.sci = 1'b1;
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) tick();
    check("rst_mid no abort", 32'(abort_cnt - ab0), 0);
    check("rst_mid no rx_valid", 32'(rx_cnt - rx0), 0);
    bus.sci = 1'b0;
    m_full  = 1'b0;
    rst_n   = 1'b1;
    repeat (4) tick();
    send_frame(frame(8'h9D), frame(8'h2B), 11, 1'b0, 8'h00, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
